flash_sample_sequencer: RTL and testbench
=========================================

# flash_sample_sequencer

Parametrised flash playback sequencer with run-time start/end bounds. It walks a word-address range forward or in reverse, in loop or one-shot mode, with pause and restart. It issues one read per word to the flash read controller and splits each returned word into two audio samples, one per `sample_tick`. It sits between the flash interface and the audio output path.

## Interface
Parameters:
- `ADDR_W`, 23, width of word address.
- `DATA_W`, 32, flash word width; must equal 2*`SAMPLE_W`.
- `SAMPLE_W`, 16, audio sample width.

Ports (name, direction, width, meaning):
- `CLOCK_50`, in, 1, clock.
- `reset`, in, 1, reset: asynchronous, active-high.
- `enable`, in, 1, 1 = play, 0 = pause.
- `direction`, in, 1, 0 = forward, 1 = reverse.
- `loop_mode`, in, 1, 1 = wrap at range end, 0 = stop (one-shot).
- `restart`, in, 1, one-cycle pulse; reload the address from the bounds.
- `start_addr`, in, `ADDR_W`, lower bound, inclusive.
- `end_addr`, in, `ADDR_W`, upper bound, inclusive.
- `sample_tick`, in, 1, one-cycle request for the next sample; already synchronous to `CLOCK_50`.
- `flash_read`, out, 1, one-cycle read request.
- `flash_addr`, out, `ADDR_W`, address of the current word.
- `flash_readdatavalid`, in, 1, returned data is valid this cycle.
- `flash_readdata`, in, `DATA_W`, returned word.
- `sample_out`, out, `SAMPLE_W`, current sample; held between updates.
- `sample_valid`, out, 1, one-cycle pulse when `sample_out` updates.
- `underrun`, out, 1, one-cycle pulse when a tick arrives with no word available.
- `done`, out, 1, level; one-shot range finished.
- `range_err`, out, 1, level; `start_addr` > `end_addr` at the last (re)load.

## Operation
- Reset values: state IDLE, `flash_addr` 0, `sample_out` 0. All 1-bit outputs are 0.
- States:
  - IDLE → LOAD when `enable`=1.
  - LOAD:
    - Latch the bounds.
    - If `start_addr` > `end_addr`: set `range_err`, go to ERR.
    - Otherwise set `flash_addr` = `start_addr` (forward) or `end_addr` (reverse), then go to REQ.
  - REQ: `flash_read`=1 for exactly one cycle → WAIT.
  - WAIT:
    - On `flash_readdatavalid`, latch the word and latch the current `direction` into `word_dir` → TICK0.
    - `flash_read` is never reasserted while waiting.
  - TICK0: on `sample_tick` with `enable`=1, emit the first half → TICK1.
    - `word_dir`=0: first half is `readdata[SAMPLE_W-1:0]`.
    - `word_dir`=1: first half is the upper half.
  - TICK1: on `sample_tick` with `enable`=1, emit the other half, advance the address → REQ or DONE.
  - DONE: `done`=1; `flash_read` stays 0; exit only by `restart` or `reset`.
  - ERR: `range_err`=1; exit only by `restart` (→ LOAD) or `reset`.
- Address advance uses the live `direction` at advance time:
  - Forward: if `flash_addr` == end, go to start when `loop_mode`=1, else DONE. Otherwise increment by 1.
  - Reverse: if `flash_addr` == start, go to end when `loop_mode`=1, else DONE. Otherwise decrement by 1.
  - Arithmetic is modulo 2^`ADDR_W`; the bounds checks make overflow unreachable.
- Pause (`enable`=0):
  - Ticks in TICK0/TICK1 are ignored, with no `underrun`.
  - REQ/WAIT still complete, and the fetched word is held.
- Underrun: `sample_tick` in REQ or WAIT with `enable`=1 pulses `underrun` the next cycle. The tick is dropped and `sample_out` is unchanged.
- Restart:
  - Priority: `restart` overrides everything except `reset`.
  - From IDLE, TICK0, TICK1, DONE or ERR: go to LOAD next cycle and clear `done`/`range_err`.
  - In WAIT: set `restart_pending`. The incoming `readdatavalid` word is discarded, then go to LOAD.
  - In REQ: the read is issued, then handled as in WAIT.
- A `restart` coincident with `sample_tick` discards the tick: no `sample_valid`, no `underrun`.
- The bounds are only sampled in LOAD. Changes while playing take effect on the next restart.

## Timing
- `sample_valid` and the new `sample_out` appear 1 cycle after the accepted tick (registered).
- `flash_read` rises 1 cycle after LOAD, and 1 cycle after the second-sample tick is accepted.
- Word-level latency: the tick accepted in TICK1 at cycle t gives `flash_read` at t+1 with the new `flash_addr` valid the same cycle. The next word is usable the cycle after `readdatavalid`.
- `done` rises 1 cycle after the final second-sample tick. That final tick's `sample_valid` still pulses.
- `underrun` is a single cycle per dropped tick. Back-to-back ticks give back-to-back pulses.
- Asynchronous `reset` mid-read: return to IDLE immediately. A later stray `readdatavalid` in IDLE is ignored.

## Test plan
- Forward loop:
  - Stimulus: start=0, end=2, words W0..W2 = 0xAAAA0001, 0xBBBB0002, 0xCCCC0003; 8 ticks.
  - Response: reads at 0,1,2,0; samples 0001, AAAA, 0002, BBBB, 0003, CCCC, 0001, AAAA; `done`=0.
- Reverse one-shot:
  - Stimulus: start=4, end=6, `loop_mode`=0.
  - Response: reads at 6,5,4, upper half first. `done`=1 after the 6th sample; no further `flash_read` for 100 cycles.
- Pause: `enable`=0 in TICK1 with 5 ticks → no `sample_valid`, no `underrun`, `sample_out` held. On `enable`=1, the next tick emits the second half.
- Restart in WAIT:
  - Stimulus: pulse `restart` while a read to addr 9 is outstanding (start=3).
  - Response: the returned word is never emitted; the next `flash_read` has `flash_addr`=3.
- Underrun: tick during WAIT → `underrun` pulses 1 cycle later, no `sample_valid`. The next tick after data arrives emits the first half.
- Range error: start=10, end=5, `enable`=1 → `range_err`=1, `flash_read` never asserted. `restart` with start=5, end=10 clears it and reads addr 5.

Source files
------------

// File: rtl/flash_sample_sequencer.sv
// flash_sample_sequencer: walks a word-address window in flash, forward or
// reverse, one-shot or looping, issuing one read per word and splitting each
// returned word into two audio samples handed out on successive sample_tick.
module flash_sample_sequencer #(
  parameter int ADDR_W   = 23,
  parameter int DATA_W   = 32,
  parameter int SAMPLE_W = 16
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                enable,
  input  logic                direction,
  input  logic                loop_mode,
  input  logic                restart,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W-1:0]   end_addr,
  input  logic                sample_tick,
  output logic                flash_read,
  output logic [ADDR_W-1:0]   flash_addr,
  input  logic                flash_readdatavalid,
  input  logic [DATA_W-1:0]   flash_readdata,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                underrun,
  output logic                done,
  output logic                range_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_WAIT,
    S_TICK0,
    S_TICK1,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   flash_addr_q, flash_addr_d;
  logic [ADDR_W-1:0]   start_q, start_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic                word_dir_q, word_dir_d;
  logic                restart_pending_q, restart_pending_d;
  logic [SAMPLE_W-1:0] sample_out_q, sample_out_d;
  logic                sample_valid_q, sample_valid_d;
  logic                underrun_q, underrun_d;

  logic [SAMPLE_W-1:0] word_lo, word_hi;
  logic                tick_ok;
  logic                tick_starved;

  assign word_lo      = word_q[SAMPLE_W-1:0];
  assign word_hi      = word_q[DATA_W-1:SAMPLE_W];
  // A restart in the same cycle swallows the tick entirely.
  assign tick_ok      = sample_tick & enable & ~restart;
  assign tick_starved = tick_ok;

  // State register and datapath flops.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q           <= S_IDLE;
      flash_addr_q      <= '0;
      start_q           <= '0;
      end_q             <= '0;
      word_q            <= '0;
      word_dir_q        <= 1'b0;
      restart_pending_q <= 1'b0;
      sample_out_q      <= '0;
      sample_valid_q    <= 1'b0;
      underrun_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      flash_addr_q      <= flash_addr_d;
      start_q           <= start_d;
      end_q             <= end_d;
      word_q            <= word_d;
      word_dir_q        <= word_dir_d;
      restart_pending_q <= restart_pending_d;
      sample_out_q      <= sample_out_d;
      sample_valid_q    <= sample_valid_d;
      underrun_q        <= underrun_d;
    end
  end

  // Next-state, address advance and sample selection.
  always_comb begin
    state_d           = state_q;
    flash_addr_d      = flash_addr_q;
    start_d           = start_q;
    end_d             = end_q;
    word_d            = word_q;
    word_dir_d        = word_dir_q;
    restart_pending_d = restart_pending_q;
    sample_out_d      = sample_out_q;
    sample_valid_d    = 1'b0;
    underrun_d        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (restart || enable) state_d = S_LOAD;
      end

      S_LOAD: begin
        start_d           = start_addr;
        end_d             = end_addr;
        restart_pending_d = 1'b0;
        if (restart) begin
          state_d = S_LOAD;
        end else if (start_addr > end_addr) begin
          state_d = S_ERR;
        end else begin
          flash_addr_d = direction ? end_addr : start_addr;
          state_d      = S_REQ;
        end
      end

      // The read has already been issued this cycle, so a restart here is
      // deferred until the matching data returns, exactly as in S_WAIT.
      S_REQ: begin
        underrun_d = tick_starved;
        if (restart) restart_pending_d = 1'b1;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        underrun_d = tick_starved;
        if (flash_readdatavalid) begin
          if (restart_pending_q || restart) begin
            restart_pending_d = 1'b0;
            state_d           = S_LOAD;
          end else begin
            word_d     = flash_readdata;
            word_dir_d = direction;
            state_d    = S_TICK0;
          end
        end else if (restart) begin
          restart_pending_d = 1'b1;
        end
      end

      S_TICK0: begin
        if (restart) begin
          state_d = S_LOAD;
        end else if (tick_ok) begin
          sample_out_d   = word_dir_q ? word_hi : word_lo;
          sample_valid_d = 1'b1;
          state_d        = S_TICK1;
        end
      end

      S_TICK1: begin
        if (restart) begin
          state_d = S_LOAD;
        end else if (tick_ok) begin
          sample_out_d   = word_dir_q ? word_lo : word_hi;
          sample_valid_d = 1'b1;
          state_d        = S_REQ;
          if (!direction) begin
            if (flash_addr_q == end_q) begin
              if (loop_mode) flash_addr_d = start_q;
              else           state_d      = S_DONE;
            end else begin
              flash_addr_d = flash_addr_q + ADDR_ONE;
            end
          end else begin
            if (flash_addr_q == start_q) begin
              if (loop_mode) flash_addr_d = end_q;
              else           state_d      = S_DONE;
            end else begin
              flash_addr_d = flash_addr_q - ADDR_ONE;
            end
          end
        end
      end

      S_DONE, S_ERR: begin
        if (restart) state_d = S_LOAD;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign flash_read   = (state_q == S_REQ);
  assign flash_addr   = flash_addr_q;
  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign underrun     = underrun_q;
  assign done         = (state_q == S_DONE);
  assign range_err    = (state_q == S_ERR);

endmodule

// File: tb/tb_flash_sample_sequencer.sv
// Directed bench for flash_sample_sequencer with a simple fixed-latency flash
// responder and a negedge monitor that logs reads, samples and underruns.
module tb_flash_sample_sequencer;

  localparam int ADDR_W   = 23;
  localparam int DATA_W   = 32;
  localparam int SAMPLE_W = 16;

  logic                CLOCK_50 = 1'b0;
  logic                reset = 1'b1;
  logic                enable = 1'b0;
  logic                direction = 1'b0;
  logic                loop_mode = 1'b0;
  logic                restart = 1'b0;
  logic [ADDR_W-1:0]   start_addr = '0;
  logic [ADDR_W-1:0]   end_addr = '0;
  logic                sample_tick = 1'b0;
  logic                flash_read;
  logic [ADDR_W-1:0]   flash_addr;
  logic                flash_readdatavalid = 1'b0;
  logic [DATA_W-1:0]   flash_readdata = '0;
  logic [SAMPLE_W-1:0] sample_out;
  logic                sample_valid;
  logic                underrun;
  logic                done;
  logic                range_err;

  int vectors = 0;
  int miscompares = 0;

  logic [DATA_W-1:0]   mem [0:15];
  int                  lat = 2;
  int                  rd_cnt = 0;
  logic [ADDR_W-1:0]   rd_addr = '0;
  logic [ADDR_W-1:0]   reads_q [$];
  logic [SAMPLE_W-1:0] samples_q [$];
  int                  underruns = 0;

  flash_sample_sequencer #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .SAMPLE_W(SAMPLE_W)
  ) dut (
    .CLOCK_50           (CLOCK_50),
    .reset              (reset),
    .enable             (enable),
    .direction          (direction),
    .loop_mode          (loop_mode),
    .restart            (restart),
    .start_addr         (start_addr),
    .end_addr           (end_addr),
    .sample_tick        (sample_tick),
    .flash_read         (flash_read),
    .flash_addr         (flash_addr),
    .flash_readdatavalid(flash_readdatavalid),
    .flash_readdata     (flash_readdata),
    .sample_out         (sample_out),
    .sample_valid       (sample_valid),
    .underrun           (underrun),
    .done               (done),
    .range_err          (range_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Flash responder and output monitor, both on the inactive edge.
  always @(negedge CLOCK_50) begin
    flash_readdatavalid = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt = rd_cnt - 1;
      if (rd_cnt == 0) begin
        flash_readdatavalid = 1'b1;
        flash_readdata      = mem[rd_addr[3:0]];
      end
    end
    if (flash_read) begin
      rd_cnt  = lat;
      rd_addr = flash_addr;
      reads_q.push_back(flash_addr);
    end
    if (sample_valid) samples_q.push_back(sample_out);
    if (underrun) underruns = underruns + 1;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
    #1;
  endtask

  task automatic do_tick();
    @(negedge CLOCK_50);
    sample_tick = 1'b1;
    @(negedge CLOCK_50);
    sample_tick = 1'b0;
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      do_tick();
      wait_cycles(8);
    end
  endtask

  task automatic do_restart();
    @(negedge CLOCK_50);
    restart = 1'b1;
    @(negedge CLOCK_50);
    restart = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    enable      = 1'b0;
    sample_tick = 1'b0;
    restart     = 1'b0;
    lat         = 2;
    wait_cycles(25);
    reset = 1'b0;
    wait_cycles(1);
    reads_q.delete();
    samples_q.delete();
    underruns = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cycles(2);
    vectors++; if (flash_addr !== 23'd0) begin miscompares++; $display("FAIL reset_addr: got %h expected %h", flash_addr, 23'd0); end
    vectors++; if (sample_out !== 16'h0) begin miscompares++; $display("FAIL reset_sample: got %h expected %h", sample_out, 16'h0); end
    vectors++; if ({flash_read, sample_valid, underrun, done, range_err} !== 5'b0) begin
      miscompares++; $display("FAIL reset_flags: got %b expected %b", {flash_read, sample_valid, underrun, done, range_err}, 5'b0);
    end
    do_reset();
    wait_cycles(5);
    vectors++; if (reads_q.size() != 0) begin miscompares++; $display("FAIL idle_no_read: got %0d expected 0", reads_q.size()); end
  endtask

  task automatic test_forward_loop();
    logic [15:0] exp_s [8];
    logic [22:0] exp_r [4];
    exp_s = '{16'h0001, 16'hAAAA, 16'h0002, 16'hBBBB, 16'h0003, 16'hCCCC, 16'h0001, 16'hAAAA};
    exp_r = '{23'd0, 23'd1, 23'd2, 23'd0};
    do_reset();
    mem[0] = 32'hAAAA0001; mem[1] = 32'hBBBB0002; mem[2] = 32'hCCCC0003;
    start_addr = 23'd0; end_addr = 23'd2; direction = 1'b0; loop_mode = 1'b1;
    @(negedge CLOCK_50); enable = 1'b1;
    wait_cycles(10);
    tick_n(8);
    vectors++; if (samples_q.size() != 8) begin miscompares++; $display("FAIL fwd_nsamples: got %0d expected 8", samples_q.size()); end
    else for (int i = 0; i < 8; i++) begin
      vectors++; if (samples_q[i] !== exp_s[i]) begin miscompares++; $display("FAIL fwd_sample[%0d]: got %h expected %h", i, samples_q[i], exp_s[i]); end
    end
    vectors++; if (reads_q.size() < 4) begin miscompares++; $display("FAIL fwd_nreads: got %0d expected >=4", reads_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      vectors++; if (reads_q[i] !== exp_r[i]) begin miscompares++; $display("FAIL fwd_read[%0d]: got %0d expected %0d", i, reads_q[i], exp_r[i]); end
    end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL fwd_done: got %b expected 0", done); end
    vectors++; if (underruns != 0) begin miscompares++; $display("FAIL fwd_underrun: got %0d expected 0", underruns); end
  endtask

  task automatic test_reverse_oneshot();
    logic [15:0] exp_s [6];
    logic [22:0] exp_r [3];
    exp_s = '{16'h6666, 16'h0606, 16'h5555, 16'h0505, 16'h4444, 16'h0404};
    exp_r = '{23'd6, 23'd5, 23'd4};
    do_reset();
    mem[4] = 32'h44440404; mem[5] = 32'h55550505; mem[6] = 32'h66660606;
    start_addr = 23'd4; end_addr = 23'd6; direction = 1'b1; loop_mode = 1'b0;
    @(negedge CLOCK_50); enable = 1'b1;
    wait_cycles(10);
    tick_n(4);
    do_tick();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rev_done_early: got %b expected 0", done); end
    wait_cycles(8);
    do_tick();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL rev_done_rise: got %b expected 1", done); end
    vectors++; if (sample_valid !== 1'b1) begin miscompares++; $display("FAIL rev_last_valid: got %b expected 1", sample_valid); end
    vectors++; if (samples_q.size() != 6) begin miscompares++; $display("FAIL rev_nsamples: got %0d expected 6", samples_q.size()); end
    else for (int i = 0; i < 6; i++) begin
      vectors++; if (samples_q[i] !== exp_s[i]) begin miscompares++; $display("FAIL rev_sample[%0d]: got %h expected %h", i, samples_q[i], exp_s[i]); end
    end
    wait_cycles(100);
    vectors++; if (reads_q.size() != 3) begin miscompares++; $display("FAIL rev_nreads: got %0d expected 3", reads_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      vectors++; if (reads_q[i] !== exp_r[i]) begin miscompares++; $display("FAIL rev_read[%0d]: got %0d expected %0d", i, reads_q[i], exp_r[i]); end
    end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL rev_done_hold: got %b expected 1", done); end
  endtask

  task automatic test_pause();
    do_reset();
    mem[0] = 32'hAAAA0001; mem[1] = 32'hBBBB0002; mem[2] = 32'hCCCC0003;
    start_addr = 23'd0; end_addr = 23'd2; direction = 1'b0; loop_mode = 1'b1;
    @(negedge CLOCK_50); enable = 1'b1;
    wait_cycles(10);
    do_tick();
    vectors++; if (sample_out !== 16'h0001) begin miscompares++; $display("FAIL pause_first: got %h expected %h", sample_out, 16'h0001); end
    @(negedge CLOCK_50); enable = 1'b0;
    tick_n(5);
    vectors++; if (samples_q.size() != 1) begin miscompares++; $display("FAIL pause_nsamples: got %0d expected 1", samples_q.size()); end
    vectors++; if (underruns != 0) begin miscompares++; $display("FAIL pause_underrun: got %0d expected 0", underruns); end
    vectors++; if (sample_out !== 16'h0001) begin miscompares++; $display("FAIL pause_held: got %h expected %h", sample_out, 16'h0001); end
    vectors++; if (reads_q.size() != 1) begin miscompares++; $display("FAIL pause_nreads: got %0d expected 1", reads_q.size()); end
    @(negedge CLOCK_50); enable = 1'b1;
    do_tick();
    vectors++; if ({sample_valid, sample_out} !== {1'b1, 16'hAAAA}) begin
      miscompares++; $display("FAIL pause_resume: got %b/%h expected 1/%h", sample_valid, sample_out, 16'hAAAA);
    end
  endtask

  task automatic test_restart_wait();
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 32'hC0000C00 + (i << 16) + i;
    start_addr = 23'd3; end_addr = 23'd12; direction = 1'b0; loop_mode = 1'b1;
    @(negedge CLOCK_50); enable = 1'b1;
    wait_cycles(10);
    tick_n(11);
    lat = 20;
    do_tick();
    wait_cycles(2);
    do_restart();
    lat = 2;
    wait_cycles(30);
    vectors++; if (reads_q.size() != 8) begin miscompares++; $display("FAIL rst_nreads: got %0d expected 8", reads_q.size()); end
    else begin
      vectors++; if (reads_q[6] !== 23'd9) begin miscompares++; $display("FAIL rst_read9: got %0d expected 9", reads_q[6]); end
      vectors++; if (reads_q[7] !== 23'd3) begin miscompares++; $display("FAIL rst_reload: got %0d expected 3", reads_q[7]); end
    end
    vectors++; if (samples_q.size() != 12) begin miscompares++; $display("FAIL rst_nsamples: got %0d expected 12", samples_q.size()); end
    do_tick();
    vectors++; if (sample_out !== 16'h0C03) begin miscompares++; $display("FAIL rst_first: got %h expected %h", sample_out, 16'h0C03); end
    wait_cycles(4);
    do_tick();
    vectors++; if (sample_out !== 16'hC003) begin miscompares++; $display("FAIL rst_second: got %h expected %h", sample_out, 16'hC003); end
  endtask

  task automatic test_underrun();
    do_reset();
    mem[0] = 32'hAAAA0001; mem[1] = 32'hBBBB0002; mem[2] = 32'hCCCC0003;
    start_addr = 23'd0; end_addr = 23'd2; direction = 1'b0; loop_mode = 1'b1;
    lat = 6;
    @(negedge CLOCK_50); enable = 1'b1;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    sample_tick = 1'b1;
    @(negedge CLOCK_50); #1;
    vectors++; if ({underrun, sample_valid} !== 2'b10) begin miscompares++; $display("FAIL ur_first: got %b expected 10", {underrun, sample_valid}); end
    @(negedge CLOCK_50); sample_tick = 1'b0; #1;
    vectors++; if ({underrun, sample_valid} !== 2'b10) begin miscompares++; $display("FAIL ur_b2b: got %b expected 10", {underrun, sample_valid}); end
    @(negedge CLOCK_50); #1;
    vectors++; if (underrun !== 1'b0) begin miscompares++; $display("FAIL ur_single: got %b expected 0", underrun); end
    wait_cycles(8);
    vectors++; if (underruns != 2) begin miscompares++; $display("FAIL ur_count: got %0d expected 2", underruns); end
    vectors++; if (samples_q.size() != 0) begin miscompares++; $display("FAIL ur_nosample: got %0d expected 0", samples_q.size()); end
    do_tick();
    vectors++; if ({sample_valid, sample_out} !== {1'b1, 16'h0001}) begin
      miscompares++; $display("FAIL ur_after: got %b/%h expected 1/%h", sample_valid, sample_out, 16'h0001);
    end
    lat = 2;
  endtask

  task automatic test_range_err();
    do_reset();
    start_addr = 23'd10; end_addr = 23'd5; direction = 1'b0; loop_mode = 1'b1;
    mem[5] = 32'h12345678;
    @(negedge CLOCK_50); enable = 1'b1;
    wait_cycles(10);
    vectors++; if (range_err !== 1'b1) begin miscompares++; $display("FAIL re_set: got %b expected 1", range_err); end
    vectors++; if (reads_q.size() != 0) begin miscompares++; $display("FAIL re_noread: got %0d expected 0", reads_q.size()); end
    start_addr = 23'd5; end_addr = 23'd10;
    do_restart();
    vectors++; if (range_err !== 1'b0) begin miscompares++; $display("FAIL re_clear: got %b expected 0", range_err); end
    wait_cycles(6);
    vectors++; if (reads_q.size() != 1) begin miscompares++; $display("FAIL re_nreads: got %0d expected 1", reads_q.size()); end
    else begin
      vectors++; if (reads_q[0] !== 23'd5) begin miscompares++; $display("FAIL re_addr: got %0d expected 5", reads_q[0]); end
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    mem[2] = 32'h2222BEEF; mem[3] = 32'h3333CAFE;
    start_addr = 23'd2; end_addr = 23'd3; direction = 1'b0; loop_mode = 1'b1;
    lat = 6;
    @(negedge CLOCK_50); enable = 1'b1;
    wait_cycles(3);
    vectors++; if (flash_addr !== 23'd2) begin miscompares++; $display("FAIL mr_pre_addr: got %0d expected 2", flash_addr); end
    #3 reset = 1'b1;
    #1;
    vectors++; if ({flash_read, flash_addr} !== {1'b0, 23'd0}) begin
      miscompares++; $display("FAIL mr_async: got %b/%0d expected 0/0", flash_read, flash_addr);
    end
    enable = 1'b0;
    lat = 2;
    wait_cycles(2);
    reset = 1'b0;
    reads_q.delete();
    wait_cycles(10);
    vectors++; if (reads_q.size() != 0 || samples_q.size() != 0) begin
      miscompares++; $display("FAIL mr_stray: got reads %0d samples %0d expected 0 0", reads_q.size(), samples_q.size());
    end
    @(negedge CLOCK_50); enable = 1'b1;
    wait_cycles(10);
    do_tick();
    vectors++; if (sample_out !== 16'hBEEF) begin miscompares++; $display("FAIL mr_replay: got %h expected %h", sample_out, 16'hBEEF); end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_forward_loop();
    test_reverse_oneshot();
    test_pause();
    test_restart_wait();
    test_underrun();
    test_range_err();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
